// File: rtl/bus_pkg.sv
// Shared bus constants, state encoding and helpers used by the arbiter and the master/slave FSMs.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_t;

    localparam int unsigned BUS_DEF_MASTERS     = 12;
    localparam int unsigned BUS_DEF_SLAVES      = 6;
    localparam int unsigned BUS_DEF_ACK_TIMEOUT = 8;
    localparam int unsigned BUS_DEF_HOLD_LIMIT  = 64;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner picker: lowest set request (fixed) or first request after ptr with wrap (round-robin).
module rr_priority_picker
    import bus_pkg::*;
#(
    parameter int unsigned N     = 12,
    parameter int unsigned MID_W = idx_w(N)
) (
    input  logic [N-1:0]     reqs,
    input  logic [MID_W-1:0] ptr,
    input  logic             mode,
    output logic [MID_W-1:0] winner,
    output logic             valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic           found;
    int unsigned    base;

    assign dbl   = {reqs, reqs};
    assign base  = 32'(ptr);
    assign valid = |reqs;

    // Window of N positions starting just above ptr; the upper copy supplies the wrap-around.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            mask[i] = (i > base) && (i <= base + N);
        end
    end

    assign masked = dbl & mask;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (mode) begin
            for (int unsigned i = 0; i < 2 * N; i++) begin
                if (!found && masked[i]) begin
                    found  = 1'b1;
                    winner = MID_W'((i >= N) ? i - N : i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && reqs[i]) begin
                    found  = 1'b1;
                    winner = MID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter: fixed/round-robin selection, slave-busy gating, ack timeout, hold-limit preemption.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 12,
    parameter int unsigned N_SLAVES    = 6,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned HOLD_LIMIT  = 64,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned MID_W      = idx_w(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N_MASTERS-1:0] m_reqs,
    input  logic [N_SLAVES-1:0]  slave_busy_in,
    input  logic                 bus_util,
    output logic [N_MASTERS-1:0] m_grants,
    output logic [MID_W-1:0]     mid_current,
    output logic [1:0]           state,
    output logic                 timeout_pulse,
    output logic                 preempt_pulse,
    output logic [CNT_W-1:0]     util_count
);

    localparam int unsigned TMR_MAX  = (ACK_TIMEOUT > HOLD_LIMIT) ? ACK_TIMEOUT : HOLD_LIMIT;
    localparam int unsigned TMR_W    = idx_w(TMR_MAX + 1);
    localparam int unsigned HOLD_TOP = (HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1;

    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_TOP);

    bus_state_t             state_q, state_d;
    logic [N_MASTERS-1:0]   grants_q, grants_d;
    logic [MID_W-1:0]       mid_q, mid_d;
    logic [MID_W-1:0]       ptr_q, ptr_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [CNT_W-1:0]       util_q, util_d;
    logic                   tmo_q, tmo_d;
    logic                   pre_q, pre_d;

    logic [MID_W-1:0]       win_idx;
    logic                   win_valid;
    logic [N_MASTERS-1:0]   win_onehot;
    logic                   others_waiting;

    rr_priority_picker #(
        .N     (N_MASTERS),
        .MID_W (MID_W)
    ) u_picker (
        .reqs   (m_reqs),
        .ptr    (ptr_q),
        .mode   (mode),
        .winner (win_idx),
        .valid  (win_valid)
    );

    assign win_onehot     = N_MASTERS'(1) << win_idx;
    assign others_waiting = |(m_reqs & ~grants_q);

    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        mid_d    = mid_q;
        ptr_d    = ptr_q;
        tmr_d    = tmr_q;
        util_d   = util_q;
        tmo_d    = 1'b0;
        pre_d    = 1'b0;

        // The acknowledging cycle in GRANT already carries the owner's traffic, so it is counted too.
        if (bus_util && (state_q == ST_GRANT || state_q == ST_BUSY) && util_q != '1) begin
            util_d = util_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_valid && !(|slave_busy_in) && !bus_util) begin
                    grants_d = win_onehot;
                    mid_d    = win_idx;
                    if (mode) begin
                        ptr_d = win_idx;
                    end
                    tmr_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus_util) begin
                    tmr_d   = '0;
                    state_d = ST_BUSY;
                end else if (tmr_q == ACK_LAST) begin
                    grants_d = '0;
                    tmo_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!bus_util) begin
                    grants_d = '0;
                    state_d  = ST_RELEASE;
                end else if (HOLD_LIMIT != 0 && tmr_q == HOLD_LAST && others_waiting) begin
                    grants_d = '0;
                    pre_d    = 1'b1;
                    state_d  = ST_RELEASE;
                end else if (tmr_q != HOLD_LAST) begin
                    // Parks at the limit so a late waiter preempts on its first cycle.
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!bus_util) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grants_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grants_q <= '0;
            mid_q    <= '0;
            ptr_q    <= MID_W'(N_MASTERS - 1);
            tmr_q    <= '0;
            util_q   <= '0;
            tmo_q    <= 1'b0;
            pre_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            mid_q    <= mid_d;
            ptr_q    <= ptr_d;
            tmr_q    <= tmr_d;
            util_q   <= util_d;
            tmo_q    <= tmo_d;
            pre_q    <= pre_d;
        end
    end

    assign m_grants      = grants_q;
    assign mid_current   = mid_q;
    assign state         = state_q;
    assign timeout_pulse = tmo_q;
    assign preempt_pulse = pre_q;
    assign util_count    = util_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: grant order is scoreboarded, other outputs are checked inline.
module tb_bus_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [11:0] m_reqs = '0;
    logic [5:0]  slave_busy_in = '0;
    logic        bus_util = 1'b0;
    logic [11:0] m_grants;
    logic [3:0]  mid_current;
    logic [1:0]  state;
    logic        timeout_pulse;
    logic        preempt_pulse;
    logic [15:0] util_count;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] sb[$];
    logic        armed = 1'b0;
    logic [11:0] prev_g = '0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .N_MASTERS   (12),
        .N_SLAVES    (6),
        .ACK_TIMEOUT (8),
        .HOLD_LIMIT  (16),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .m_reqs        (m_reqs),
        .slave_busy_in (slave_busy_in),
        .bus_util      (bus_util),
        .m_grants      (m_grants),
        .mid_current   (mid_current),
        .state         (state),
        .timeout_pulse (timeout_pulse),
        .preempt_pulse (preempt_pulse),
        .util_count    (util_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Every cycle: grant shape rules; on each new grant, pop the expected owner.
    always @(negedge clk) begin
        logic [11:0] e;
        if (armed) begin
            chk("onehot0", 32'($onehot0(m_grants)), 32'd1);
            chk("no_owner_swap", 32'(prev_g != '0 && m_grants != '0 && m_grants != prev_g), 32'd0);
            if (prev_g == '0 && m_grants != '0) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_grant", 32'(m_grants), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_grant", 32'(m_grants), 32'(e));
                end
            end
            prev_g = m_grants;
        end
    end

    task automatic serve(input int unsigned hold, input bit drop, input int unsigned exp_mid);
        int unsigned n;
        n = 0;
        while (m_grants == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("grant_wait", 32'(n < 20), 32'd1);
        chk("serve_mid", 32'(mid_current), exp_mid);
        bus_util = 1'b1;
        repeat (hold) tick();
        bus_util = 1'b0;
        if (drop) m_reqs = '0;
        n = 0;
        while (state != 2'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(n < 20), 32'd1);
    endtask

    initial begin
        int unsigned n;
        int unsigned hi;
        int unsigned busy;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_grants", 32'(m_grants), 32'd0);
        chk("rst_mid", 32'(mid_current), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tmo", 32'(timeout_pulse), 32'd0);
        chk("rst_pre", 32'(preempt_pulse), 32'd0);
        chk("rst_util", 32'(util_count), 32'd0);
        rst   = 1'b0;
        armed = 1'b1;

        // 1: single master, 10 cycles of utilisation
        mode   = 1'b0;
        m_reqs = 12'h004;
        sb.push_back(12'h004);
        tick();
        chk("t1_grant", 32'(m_grants), 32'h004);
        chk("t1_mid", 32'(mid_current), 32'd2);
        chk("t1_state_grant", 32'(state), 32'd1);
        tick();
        bus_util = 1'b1;
        repeat (10) tick();
        chk("t1_state_busy", 32'(state), 32'd2);
        bus_util = 1'b0;
        m_reqs   = '0;
        tick();
        chk("t1_state_release", 32'(state), 32'd3);
        chk("t1_grant_drop", 32'(m_grants), 32'd0);
        tick();
        chk("t1_state_idle", 32'(state), 32'd0);
        chk("t1_util", 32'(util_count), 32'd10);

        // 2: round-robin then fixed priority with masters 2,4,5 requesting
        mode   = 1'b1;
        m_reqs = 12'h034;
        sb.push_back(12'h004);
        sb.push_back(12'h010);
        sb.push_back(12'h020);
        sb.push_back(12'h004);
        serve(4, 1'b0, 2);
        serve(4, 1'b0, 4);
        serve(4, 1'b0, 5);
        serve(4, 1'b1, 2);
        mode   = 1'b0;
        m_reqs = 12'h034;
        repeat (3) sb.push_back(12'h004);
        serve(4, 1'b0, 2);
        serve(4, 1'b0, 2);
        serve(4, 1'b1, 2);

        // 3: master 3 never acknowledges; master 7 is next in rotation
        mode   = 1'b1;
        m_reqs = 12'h088;
        sb.push_back(12'h008);
        sb.push_back(12'h080);
        tick();
        chk("t3_grant", 32'(m_grants), 32'h008);
        chk("t3_mid", 32'(mid_current), 32'd3);
        hi = 0;
        while (m_grants == 12'h008 && hi < 20) begin
            hi++;
            tick();
        end
        chk("t3_grant_len", hi, 32'd8);
        chk("t3_tmo_pulse", 32'(timeout_pulse), 32'd1);
        chk("t3_state_idle", 32'(state), 32'd0);
        tick();
        chk("t3_next_grant", 32'(m_grants), 32'h080);
        chk("t3_tmo_single", 32'(timeout_pulse), 32'd0);
        serve(2, 1'b1, 7);

        // 4: hold-limit preemption of master 2 by master 4
        m_reqs = 12'h004;
        sb.push_back(12'h004);
        tick();
        chk("t4_grant", 32'(m_grants), 32'h004);
        bus_util = 1'b1;
        tick();
        chk("t4_state_busy", 32'(state), 32'd2);
        busy = 0;
        while (state == 2'd2 && busy < 40) begin
            busy++;
            if (busy == 5) m_reqs = 12'h014;
            tick();
        end
        chk("t4_busy_len", busy, 32'd16);
        chk("t4_pre_pulse", 32'(preempt_pulse), 32'd1);
        chk("t4_state_release", 32'(state), 32'd3);
        chk("t4_grant_drop", 32'(m_grants), 32'd0);
        sb.push_back(12'h010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_pre_single", 32'(preempt_pulse), 32'd0);
            chk("t4_wait_release", 32'(m_grants), 32'd0);
        end
        bus_util = 1'b0;
        m_reqs   = 12'h010;
        tick();
        chk("t4_state_idle", 32'(state), 32'd0);
        chk("t4_gap", 32'(m_grants), 32'd0);
        tick();
        chk("t4_next_grant", 32'(m_grants), 32'h010);
        serve(2, 1'b1, 4);

        // 5: slave busy gating, then reset during BUSY
        slave_busy_in = 6'b001000;
        m_reqs        = 12'h020;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_blocked", 32'(m_grants), 32'd0);
        end
        sb.push_back(12'h020);
        slave_busy_in = '0;
        tick();
        chk("t5_grant", 32'(m_grants), 32'h020);
        bus_util = 1'b1;
        tick();
        tick();
        chk("t5_state_busy", 32'(state), 32'd2);
        chk("t5_util_nonzero", 32'(util_count != '0), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rst_grants", 32'(m_grants), 32'd0);
        chk("t5_rst_util", 32'(util_count), 32'd0);
        chk("t5_rst_state", 32'(state), 32'd0);
        chk("t5_rst_mid", 32'(mid_current), 32'd0);
        rst      = 1'b0;
        bus_util = 1'b0;
        m_reqs   = '0;
        n = 0;
        repeat (2) tick();
        chk("t5_quiet", 32'(m_grants), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
